// File: rtl/ram_writer_if.sv
// Producer-side write port and MIG user-interface write/command port of ram_writer.
// The slave modport is the ram_writer view; master is the view of whatever drives it.
interface ram_writer_if;
   logic [26:0] write_address;
   logic [15:0] write_data_in;
   logic        write_data_valid;
   logic        write_ready;
   logic        flush;
   logic        idle;
   logic [26:0] ram_address;
   logic [2:0]  ram_cmd;
   logic        ram_en;
   logic        ram_rdy;
   logic [63:0] ram_wdf_data;
   logic [7:0]  ram_wdf_mask;
   logic        ram_wdf_wren;
   logic        ram_wdf_end;
   logic        ram_wdf_rdy;

   // valid/ready: a word, command or data beat transfers on a rising clk edge where the
   // sender's strobe and the receiver's ready are both 1; the sender holds it stable until then.
   modport slave (
      input  write_address, write_data_in, write_data_valid, flush, ram_rdy, ram_wdf_rdy,
      output write_ready, idle, ram_address, ram_cmd, ram_en,
             ram_wdf_data, ram_wdf_mask, ram_wdf_wren, ram_wdf_end
   );

   modport master (
      output write_address, write_data_in, write_data_valid, flush, ram_rdy, ram_wdf_rdy,
      input  write_ready, idle, ram_address, ram_cmd, ram_en,
             ram_wdf_data, ram_wdf_mask, ram_wdf_wren, ram_wdf_end
   );
endinterface

// File: rtl/ram_writer.sv
// Coalesces 16-bit word writes into one 8-word burst and writes it to a MIG user interface
// as one write command plus two 64-bit beats (upper half first); unwritten words are byte-masked.
module ram_writer (
   input  logic         clk,
   input  logic         reset,
   ram_writer_if.slave  bus,
   output logic [1:0]   state_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND_CMD = 2'd1,
      ST_WR_BEAT0 = 2'd2,
      ST_WR_BEAT1 = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  burst_q, burst_d;
   logic [7:0]    wmask_q, wmask_d;
   logic [23:0]   base_q, base_d;
   logic          pend_q, pend_d;
   logic [26:0]   pend_addr_q, pend_addr_d;
   logic [15:0]   pend_data_q, pend_data_d;
   logic [63:0]   wdf_data_q, wdf_data_d;
   logic [7:0]    wdf_mask_q, wdf_mask_d;
   logic [2:0]    widx;
   logic [2:0]    pidx;

   function automatic logic [7:0] expand(input logic [3:0] m);
      expand = {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
   endfunction

   assign widx = bus.write_address[2:0];
   assign pidx = pend_addr_q[2:0];

   always_comb begin
      state_d     = state_q;
      burst_d     = burst_q;
      wmask_d     = wmask_q;
      base_d      = base_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.write_data_valid) begin
               if (wmask_q != 8'h00 && bus.write_address[26:3] != base_q) begin
                  // New burst address: park the word and drain the old burst first.
                  pend_d      = 1'b1;
                  pend_addr_d = bus.write_address;
                  pend_data_d = bus.write_data_in;
                  state_d     = ST_SEND_CMD;
               end else begin
                  base_d                         = bus.write_address[26:3];
                  burst_d[{widx, 4'b0000} +: 16] = bus.write_data_in;
                  wmask_d[widx]                  = 1'b1;
                  if (wmask_d == 8'hFF || bus.flush) state_d = ST_SEND_CMD;
               end
            end else if (bus.flush && wmask_q != 8'h00) begin
               state_d = ST_SEND_CMD;
            end
         end
         ST_SEND_CMD: begin
            if (bus.ram_rdy) state_d = ST_WR_BEAT0;
         end
         ST_WR_BEAT0: begin
            if (bus.ram_wdf_rdy) state_d = ST_WR_BEAT1;
         end
         ST_WR_BEAT1: begin
            if (bus.ram_wdf_rdy) begin
               burst_d = '0;
               wmask_d = '0;
               if (pend_q) begin
                  base_d                         = pend_addr_q[26:3];
                  burst_d[{pidx, 4'b0000} +: 16] = pend_data_q;
                  wmask_d[pidx]                  = 1'b1;
                  pend_d                         = 1'b0;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Beat data/mask are registered, so they are prepared from the state being entered.
      wdf_data_d = '0;
      wdf_mask_d = 8'hFF;
      if (state_d == ST_WR_BEAT0) begin
         wdf_data_d = burst_q[127:64];
         wdf_mask_d = ~expand(wmask_q[7:4]);
      end else if (state_d == ST_WR_BEAT1) begin
         wdf_data_d = burst_q[63:0];
         wdf_mask_d = ~expand(wmask_q[3:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         burst_q     <= '0;
         wmask_q     <= '0;
         base_q      <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         wdf_data_q  <= '0;
         wdf_mask_q  <= 8'hFF;
      end else begin
         state_q     <= state_d;
         burst_q     <= burst_d;
         wmask_q     <= wmask_d;
         base_q      <= base_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         wdf_data_q  <= wdf_data_d;
         wdf_mask_q  <= wdf_mask_d;
      end
   end

   // Strobes are gated by reset so an in-flight transfer stops the moment reset is asserted.
   assign bus.write_ready  = reset && (state_q == ST_IDLE);
   assign bus.idle         = reset && (state_q == ST_IDLE) && (wmask_q == 8'h00) && !pend_q;
   assign bus.ram_en       = reset && (state_q == ST_SEND_CMD);
   assign bus.ram_cmd      = 3'b000;
   assign bus.ram_address  = {base_q, 3'b000};
   assign bus.ram_wdf_wren = reset && (state_q == ST_WR_BEAT0 || state_q == ST_WR_BEAT1);
   assign bus.ram_wdf_end  = reset && (state_q == ST_WR_BEAT1);
   assign bus.ram_wdf_data = wdf_data_q;
   assign bus.ram_wdf_mask = wdf_mask_q;
   assign state_o          = state_q;

endmodule
